// File: rtl/hssi_tx_pkt_arb.sv
// Packet-atomic round-robin merge of NUM_CH AXI-S TX streams into one registered stream.
// Each output beat carries its source channel on m_tid.
module hssi_tx_pkt_arb #(
  parameter  int NUM_CH = 8,
  parameter  int DATA_W = 64,
  parameter  int USER_W = 12,
  localparam int ID_W   = $clog2(NUM_CH),
  localparam int KEEP_W = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        s_tvalid,
  output logic [NUM_CH-1:0]        s_tready,
  input  logic [NUM_CH*DATA_W-1:0] s_tdata,
  input  logic [NUM_CH*KEEP_W-1:0] s_tkeep,
  input  logic [NUM_CH*USER_W-1:0] s_tuser,
  input  logic [NUM_CH-1:0]        s_tlast,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [DATA_W-1:0]        m_tdata,
  output logic [KEEP_W-1:0]        m_tkeep,
  output logic [USER_W-1:0]        m_tuser,
  output logic                     m_tlast,
  output logic [ID_W-1:0]          m_tid,
  output logic [31:0]              pkt_cnt,
  output logic                     busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  logic [0:0]        r_state;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_grant;
  logic              r_m_tvalid;
  logic [DATA_W-1:0] r_m_tdata;
  logic [KEEP_W-1:0] r_m_tkeep;
  logic [USER_W-1:0] r_m_tuser;
  logic              r_m_tlast;
  logic [ID_W-1:0]   r_m_tid;
  logic [31:0]       r_pkt_cnt;

  logic [ID_W-1:0]   w_sel;
  logic [ID_W:0]     w_sum;
  logic [ID_W-1:0]   w_idx;
  logic              w_out_ok;
  logic              w_accept;
  logic [NUM_CH-1:0] w_s_tready;

  assign w_out_ok = !r_m_tvalid || m_tready;
  assign w_accept = (r_state == XFER) && s_tvalid[r_grant] && w_out_ok;

  // Scan downward so the lowest offset from r_ptr is the last (winning) assignment.
  always_comb begin
    w_sel = r_ptr;
    w_sum = '0;
    w_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(NUM_CH))
        w_sum = w_sum - (ID_W+1)'(NUM_CH);
      w_idx = w_sum[ID_W-1:0];
      if (s_tvalid[w_idx])
        w_sel = w_idx;
    end
  end

  always_comb begin
    w_s_tready = '0;
    if (r_state == XFER)
      w_s_tready[r_grant] = w_out_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tkeep  <= '0;
      r_m_tuser  <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tid    <= '0;
      r_pkt_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|s_tvalid) begin
            r_grant <= w_sel;
            r_state <= XFER;
          end
        end
        XFER: begin
          if (w_accept && s_tlast[r_grant]) begin
            r_ptr   <= (r_grant == ID_W'(NUM_CH - 1)) ? '0 : r_grant + 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_accept) begin
        r_m_tvalid <= 1'b1;
        r_m_tdata  <= s_tdata[int'(r_grant)*DATA_W +: DATA_W];
        r_m_tkeep  <= s_tkeep[int'(r_grant)*KEEP_W +: KEEP_W];
        r_m_tuser  <= s_tuser[int'(r_grant)*USER_W +: USER_W];
        r_m_tlast  <= s_tlast[r_grant];
        r_m_tid    <= r_grant;
      end else if (m_tready) begin
        r_m_tvalid <= 1'b0;
      end

      if (r_m_tvalid && m_tready && r_m_tlast)
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
    end
  end

  assign s_tready = w_s_tready;
  assign m_tvalid = r_m_tvalid;
  assign m_tdata  = r_m_tdata;
  assign m_tkeep  = r_m_tkeep;
  assign m_tuser  = r_m_tuser;
  assign m_tlast  = r_m_tlast;
  assign m_tid    = r_m_tid;
  assign pkt_cnt  = r_pkt_cnt;
  assign busy     = (r_state == XFER);

endmodule
